// File: rtl/sseg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_ctrl_pkg
// Description : Shared constants and helpers for the 4-digit common-anode
//               seven-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_scan_ctrl_pkg;

    // Display geometry
    localparam int c_NUM_DIGITS = 4;
    localparam int c_IDX_W      = $clog2(c_NUM_DIGITS);

    // BCD code that forces a dark digit
    localparam logic [3:0] c_BLANK_CODE = 4'hF;

    // Per-slot state encoding
    localparam logic [0:0] c_ST_BLANK = 1'b0;
    localparam logic [0:0] c_ST_DRIVE = 1'b1;

    // All-off pin levels (everything active low)
    localparam logic [3:0] c_AN_OFF   = 4'hF;
    localparam logic [6:0] c_SSEG_OFF = 7'h7F;

    // Glyph shown for the illegal codes 10..14: segments a, d, g lit
    localparam logic [6:0] c_SSEG_ERR = 7'b0110110;

    typedef logic [3:0] bcd_digit_t;

    // Active-low one-hot anode select for a digit index
    function automatic logic [3:0] anode_sel(input logic [c_IDX_W-1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage : sseg_scan_ctrl_pkg
`default_nettype wire

// File: rtl/sseg_scan_ctrl_bcd2sseg.sv
`default_nettype none
// ============================================================================
// Module      : bcd2sseg
// Description : Combinational BCD to seven-segment decoder, active-low
//               segments in gfedcba order. Codes 10..14 produce the error
//               glyph; code 15 produces a dark digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd2sseg
    import sseg_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_sseg
);

    // Glyph lookup
    always_comb begin
        o_sseg = c_SSEG_OFF;
        case (i_bcd)
            4'd0:    o_sseg = 7'b1000000;
            4'd1:    o_sseg = 7'b1111001;
            4'd2:    o_sseg = 7'b0100100;
            4'd3:    o_sseg = 7'b0110000;
            4'd4:    o_sseg = 7'b0011001;
            4'd5:    o_sseg = 7'b0010010;
            4'd6:    o_sseg = 7'b0000010;
            4'd7:    o_sseg = 7'b1111000;
            4'd8:    o_sseg = 7'b0000000;
            4'd9:    o_sseg = 7'b0010000;
            4'd10,
            4'd11,
            4'd12,
            4'd13,
            4'd14:   o_sseg = c_SSEG_ERR;
            default: o_sseg = c_SSEG_OFF;
        endcase
    end

endmodule : bcd2sseg
`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_ctrl
// Description : Time-multiplexed controller for a 4-digit common-anode
//               seven-segment display. Per-digit slot with leading dead time,
//               leading-zero blanking, and a shadow/active register pair so
//               new values only take effect on a frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_ctrl
    import sseg_scan_ctrl_pkg::*;
#(
    parameter int PRESCALE = 25000,
    parameter int DEAD     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        lzb,
    input  logic        update,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  sseg,
    output logic        dp,
    output logic        frame_start
);

    localparam int                   c_CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX  = c_CNT_W'(PRESCALE - 1);
    localparam logic [c_CNT_W-1:0]   c_DEAD     = c_CNT_W'(DEAD);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST = c_IDX_W'(c_NUM_DIGITS - 1);

    // Scan state
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic [0:0]         r_state;

    // Value registers
    logic [15:0] r_shadow;
    logic [3:0]  r_shadow_dp;
    logic        r_pending;
    logic [15:0] r_active;
    logic [3:0]  r_active_dp;

    // Combinational helpers
    logic               w_slot_end;
    logic               w_frame_end;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    bcd_digit_t         w_digit;
    logic               w_dp_bit;
    logic [6:0]         w_dec_sseg;
    logic [3:0]         w_lz;
    logic               w_dark;
    logic [3:0]         w_an_nxt;
    logic [6:0]         w_sseg_nxt;
    logic               w_dp_nxt;
    logic               w_fs_nxt;

    assign w_slot_end  = (r_cnt == c_CNT_MAX);
    assign w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);
    assign w_cnt_nxt   = w_slot_end ? '0 : r_cnt + c_CNT_W'(1);

    // Slot prescaler, digit index and per-slot BLANK/DRIVE state.
    // r_state always describes the slot position currently held in r_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= c_ST_BLANK;
        end else begin
            r_cnt   <= w_cnt_nxt;
            if (w_slot_end) begin
                r_idx <= r_idx + c_IDX_W'(1);
            end
            r_state <= (w_cnt_nxt < c_DEAD) ? c_ST_BLANK : c_ST_DRIVE;
        end
    end

    // Shadow capture and frame-synchronous transfer to the active value.
    // An update landing on the boundary cycle bypasses the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= '0;
            r_shadow_dp <= '0;
            r_pending   <= 1'b0;
            r_active    <= '0;
            r_active_dp <= '0;
        end else begin
            if (update) begin
                r_shadow    <= bcd_in;
                r_shadow_dp <= dp_in;
            end
            if (w_frame_end) begin
                if (update) begin
                    r_active    <= bcd_in;
                    r_active_dp <= dp_in;
                end else if (r_pending) begin
                    r_active    <= r_shadow;
                    r_active_dp <= r_shadow_dp;
                end
                r_pending <= 1'b0;
            end else if (update) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Select the digit and DP bit for the current slot
    always_comb begin
        w_digit  = r_active[3:0];
        w_dp_bit = r_active_dp[0];
        case (r_idx)
            2'd1: begin
                w_digit  = r_active[7:4];
                w_dp_bit = r_active_dp[1];
            end
            2'd2: begin
                w_digit  = r_active[11:8];
                w_dp_bit = r_active_dp[2];
            end
            2'd3: begin
                w_digit  = r_active[15:12];
                w_dp_bit = r_active_dp[3];
            end
            default: begin
                w_digit  = r_active[3:0];
                w_dp_bit = r_active_dp[0];
            end
        endcase
    end

    // w_lz[i]: digit i and everything above it are zero; digit 0 never qualifies
    assign w_lz[3] = (r_active[15:12] == 4'd0);
    assign w_lz[2] = w_lz[3] && (r_active[11:8] == 4'd0);
    assign w_lz[1] = w_lz[2] && (r_active[7:4] == 4'd0);
    assign w_lz[0] = 1'b0;

    bcd2sseg u_bcd2sseg (
        .i_bcd  (w_digit),
        .o_sseg (w_dec_sseg)
    );

    assign w_dark = (w_digit == c_BLANK_CODE) || (lzb && w_lz[r_idx]);

    // Next pin values; the DP follows its mask even on a dark digit
    always_comb begin
        w_an_nxt   = c_AN_OFF;
        w_sseg_nxt = c_SSEG_OFF;
        w_dp_nxt   = 1'b1;
        w_fs_nxt   = (r_cnt == '0) && (r_idx == '0);
        if (en && (r_state == c_ST_DRIVE)) begin
            w_an_nxt   = anode_sel(r_idx);
            w_sseg_nxt = w_dark ? c_SSEG_OFF : w_dec_sseg;
            w_dp_nxt   = ~w_dp_bit;
        end
    end

    // Registered pins, one cycle behind the scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= c_AN_OFF;
            sseg        <= c_SSEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= w_an_nxt;
            sseg        <= w_sseg_nxt;
            dp          <= w_dp_nxt;
            frame_start <= w_fs_nxt;
        end
    end

endmodule : sseg_scan_ctrl
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_scan_ctrl
// Description : Directed self-checking bench for sseg_scan_ctrl with
//               PRESCALE=8, DEAD=2 (32-cycle frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_ctrl;

    localparam int PRESCALE = 8;
    localparam int DEAD     = 2;

    localparam logic [6:0] G0   = 7'b1000000;
    localparam logic [6:0] G1   = 7'b1111001;
    localparam logic [6:0] G2   = 7'b0100100;
    localparam logic [6:0] G3   = 7'b0110000;
    localparam logic [6:0] G4   = 7'b0011001;
    localparam logic [6:0] G5   = 7'b0010010;
    localparam logic [6:0] G7   = 7'b1111000;
    localparam logic [6:0] G9   = 7'b0010000;
    localparam logic [6:0] GE   = 7'b0110110;
    localparam logic [6:0] GOFF = 7'h7F;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b1;
    logic        lzb    = 1'b0;
    logic        update = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic [3:0]  dp_in  = 4'b0000;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;
    logic        frame_start;

    int tests = 0;
    int fails = 0;

    logic [3:0] cap_an  [32];
    logic [6:0] cap_seg [32];
    logic       cap_dp  [32];
    logic       cap_fs  [32];

    always #5 clk = ~clk;

    sseg_scan_ctrl #(
        .PRESCALE (PRESCALE),
        .DEAD     (DEAD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .lzb         (lzb),
        .update      (update),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .an          (an),
        .sseg        (sseg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    // Record one full frame starting at the next (or current) frame_start
    task automatic capture_frame(output bit ok);
        int n = 0;
        while (frame_start !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        ok = (frame_start === 1'b1);
        for (int j = 0; j < 32; j++) begin
            if (j > 0) @(negedge clk);
            cap_an[j]  = an;
            cap_seg[j] = sseg;
            cap_dp[j]  = dp;
            cap_fs[j]  = frame_start;
        end
    endtask

    task automatic pulse_update(input logic [15:0] val, input logic [3:0] dpm);
        bcd_in = val;
        dp_in  = dpm;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({an, sseg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_values an=%b sseg=%b dp=%b fs=%b, expected 1111 1111111 1 0",
                     an, sseg, dp, frame_start);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (frame_start !== 1'b1 || an !== 4'hF) begin
            fails++;
            $display("FAIL release_first_edge fs=%b an=%b, expected fs=1 an=1111", frame_start, an);
        end
    endtask

    task automatic test_zero_scan();
        bit ok;
        logic [6:0] g [4];
        logic [3:0] m;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int s;
        bit drv;
        g = '{G0, G0, G0, G0};
        m = 4'b0000;
        capture_frame(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL zero_scan_timeout fs=%b expected 1", frame_start); end
        for (int j = 0; j < 32; j++) begin
            s = j / 8; drv = (j % 8) >= DEAD;
            e_an = drv ? ~(4'b0001 << s) : 4'hF;
            e_seg = drv ? g[s] : GOFF;
            e_dp = drv ? ~m[s] : 1'b1;
            tests++;
            if ({cap_an[j], cap_seg[j], cap_dp[j], cap_fs[j]} !== {e_an, e_seg, e_dp, (j == 0)}) begin
                fails++;
                $display("FAIL zero_scan j=%0d an=%b sseg=%b dp=%b fs=%b, expected an=%b sseg=%b dp=%b fs=%b",
                         j, cap_an[j], cap_seg[j], cap_dp[j], cap_fs[j], e_an, e_seg, e_dp, (j == 0));
            end
        end
    endtask

    task automatic test_update_midframe();
        bit ok;
        bit bad = 1'b0;
        int n = 0;
        logic [3:0] bad_an = 4'h0;
        logic [6:0] bad_seg = 7'h0;
        logic       bad_dp = 1'b0;
        logic [6:0] g [4];
        logic [3:0] m;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int s;
        bit drv;
        repeat (10) @(negedge clk);
        pulse_update(16'h1234, 4'b0100);
        while (frame_start !== 1'b1 && n < 64) begin
            if (an !== 4'hF && (sseg !== G0 || dp !== 1'b1) && !bad) begin
                bad = 1'b1; bad_an = an; bad_seg = sseg; bad_dp = dp;
            end
            @(negedge clk);
            n++;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL hold_until_frame an=%b sseg=%b dp=%b, expected sseg=%b dp=1", bad_an, bad_seg, bad_dp, G0);
        end
        g = '{G4, G3, G2, G1};
        m = 4'b0100;
        capture_frame(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL value_1234_timeout fs=%b expected 1", frame_start); end
        for (int j = 0; j < 32; j++) begin
            s = j / 8; drv = (j % 8) >= DEAD;
            e_an = drv ? ~(4'b0001 << s) : 4'hF;
            e_seg = drv ? g[s] : GOFF;
            e_dp = drv ? ~m[s] : 1'b1;
            tests++;
            if ({cap_an[j], cap_seg[j], cap_dp[j], cap_fs[j]} !== {e_an, e_seg, e_dp, (j == 0)}) begin
                fails++;
                $display("FAIL value_1234 j=%0d an=%b sseg=%b dp=%b fs=%b, expected an=%b sseg=%b dp=%b fs=%b",
                         j, cap_an[j], cap_seg[j], cap_dp[j], cap_fs[j], e_an, e_seg, e_dp, (j == 0));
            end
        end
    endtask

    task automatic test_enable();
        bit ok;
        en = 1'b0;
        capture_frame(ok);
        en = 1'b1;
        tests++;
        if (!ok) begin fails++; $display("FAIL enable_timeout fs=%b expected 1", frame_start); end
        for (int j = 0; j < 32; j++) begin
            tests++;
            if ({cap_an[j], cap_seg[j], cap_dp[j], cap_fs[j]} !== {4'hF, GOFF, 1'b1, (j == 0)}) begin
                fails++;
                $display("FAIL enable_off j=%0d an=%b sseg=%b dp=%b fs=%b, expected an=1111 sseg=1111111 dp=1 fs=%b",
                         j, cap_an[j], cap_seg[j], cap_dp[j], cap_fs[j], (j == 0));
            end
        end
    endtask

    task automatic test_lzb();
        bit ok;
        logic [6:0] g [4];
        logic [3:0] m;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int s;
        bit drv;
        lzb = 1'b1;
        repeat (4) @(negedge clk);
        pulse_update(16'h0070, 4'b1001);
        g = '{G0, G7, GOFF, GOFF};
        m = 4'b1001;
        capture_frame(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL lzb_timeout fs=%b expected 1", frame_start); end
        for (int j = 0; j < 32; j++) begin
            s = j / 8; drv = (j % 8) >= DEAD;
            e_an = drv ? ~(4'b0001 << s) : 4'hF;
            e_seg = drv ? g[s] : GOFF;
            e_dp = drv ? ~m[s] : 1'b1;
            tests++;
            if ({cap_an[j], cap_seg[j], cap_dp[j], cap_fs[j]} !== {e_an, e_seg, e_dp, (j == 0)}) begin
                fails++;
                $display("FAIL lzb_0070 j=%0d an=%b sseg=%b dp=%b fs=%b, expected an=%b sseg=%b dp=%b fs=%b",
                         j, cap_an[j], cap_seg[j], cap_dp[j], cap_fs[j], e_an, e_seg, e_dp, (j == 0));
            end
        end
    endtask

    task automatic test_error_glyph();
        bit ok;
        logic [6:0] g [4];
        logic [3:0] m;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int s;
        bit drv;
        repeat (4) @(negedge clk);
        pulse_update(16'hFA0C, 4'b0000);
        g = '{GE, G0, GE, GOFF};
        m = 4'b0000;
        capture_frame(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL error_glyph_timeout fs=%b expected 1", frame_start); end
        for (int j = 0; j < 32; j++) begin
            s = j / 8; drv = (j % 8) >= DEAD;
            e_an = drv ? ~(4'b0001 << s) : 4'hF;
            e_seg = drv ? g[s] : GOFF;
            e_dp = drv ? ~m[s] : 1'b1;
            tests++;
            if ({cap_an[j], cap_seg[j], cap_dp[j], cap_fs[j]} !== {e_an, e_seg, e_dp, (j == 0)}) begin
                fails++;
                $display("FAIL error_FA0C j=%0d an=%b sseg=%b dp=%b fs=%b, expected an=%b sseg=%b dp=%b fs=%b",
                         j, cap_an[j], cap_seg[j], cap_dp[j], cap_fs[j], e_an, e_seg, e_dp, (j == 0));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [6:0] g [4];
        logic [3:0] e_an;
        logic [6:0] e_seg;
        int s;
        bit drv;
        // From the last cycle of a frame, 31 cycles later is slot 3 position 6:
        // the update driven now is sampled on the frame-boundary edge.
        repeat (31) @(negedge clk);
        tests++;
        if (an !== 4'b0111) begin
            fails++;
            $display("FAIL boundary_align an=%b, expected 0111", an);
        end
        pulse_update(16'h9999, 4'b0000);
        @(negedge clk);
        tests++;
        if (frame_start !== 1'b1) begin
            fails++;
            $display("FAIL boundary_fs fs=%b, expected 1", frame_start);
        end
        bcd_in = 16'h5555;
        update = 1'b1;
        fork
            begin
                @(negedge clk);
                update = 1'b0;
            end
        join_none
        for (int f = 0; f < 2; f++) begin
            g = (f == 0) ? '{G9, G9, G9, G9} : '{G5, G5, G5, G5};
            capture_frame(ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL b2b_timeout frame=%0d fs=%b expected 1", f, frame_start); end
            for (int j = 0; j < 32; j++) begin
                s = j / 8; drv = (j % 8) >= DEAD;
                e_an = drv ? ~(4'b0001 << s) : 4'hF;
                e_seg = drv ? g[s] : GOFF;
                tests++;
                if ({cap_an[j], cap_seg[j], cap_dp[j], cap_fs[j]} !== {e_an, e_seg, 1'b1, (j == 0)}) begin
                    fails++;
                    $display("FAIL b2b frame=%0d j=%0d an=%b sseg=%b dp=%b fs=%b, expected an=%b sseg=%b dp=1 fs=%b",
                             f, j, cap_an[j], cap_seg[j], cap_dp[j], cap_fs[j], e_an, e_seg, (j == 0));
                end
            end
        end
    endtask

    task automatic test_reset_midslot();
        bit ok;
        logic [6:0] g [4];
        logic [3:0] e_an;
        logic [6:0] e_seg;
        int s;
        bit drv;
        repeat (11) @(negedge clk);
        pulse_update(16'h8888, 4'b1111);
        repeat (9) @(negedge clk);
        tests++;
        if (an !== 4'b1011) begin
            fails++;
            $display("FAIL midslot_align an=%b, expected 1011", an);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({an, sseg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL async_reset an=%b sseg=%b dp=%b fs=%b, expected 1111 1111111 1 0",
                     an, sseg, dp, frame_start);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (frame_start !== 1'b1) begin
            fails++;
            $display("FAIL rerelease_fs fs=%b, expected 1", frame_start);
        end
        g = '{G0, GOFF, GOFF, GOFF};
        for (int f = 0; f < 2; f++) begin
            capture_frame(ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL post_reset_timeout frame=%0d fs=%b expected 1", f, frame_start); end
            for (int j = 0; j < 32; j++) begin
                s = j / 8; drv = (j % 8) >= DEAD;
                e_an = drv ? ~(4'b0001 << s) : 4'hF;
                e_seg = drv ? g[s] : GOFF;
                tests++;
                if ({cap_an[j], cap_seg[j], cap_dp[j], cap_fs[j]} !== {e_an, e_seg, 1'b1, (j == 0)}) begin
                    fails++;
                    $display("FAIL post_reset frame=%0d j=%0d an=%b sseg=%b dp=%b fs=%b, expected an=%b sseg=%b dp=1 fs=%b",
                             f, j, cap_an[j], cap_seg[j], cap_dp[j], cap_fs[j], e_an, e_seg, (j == 0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_scan();
        test_update_midframe();
        test_enable();
        test_lzb();
        test_error_glyph();
        test_back_to_back();
        test_reset_midslot();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sseg_scan_ctrl
`default_nettype wire

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Time-multiplexed controller for a 4-digit, common-anode seven-segment display. Holds a packed 4-digit BCD value plus decimal-point mask, cycles one digit at a time through the BCD-to-segment decoder, and drives active-low anode and segment lines. Includes inter-digit dead time against ghosting and frame-synchronous value update against tearing. Sits between the stopwatch counter and the board display pins.

## Interface
- PRESCALE, default 25000: clock cycles per digit slot; minimum 4.
- DEAD, default 16: blanked cycles at the start of each slot; 1 ≤ DEAD < PRESCALE.
- clk  input  1  system clock; all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  display enable; low blanks all outputs, counters keep running.
- lzb  input  1  leading-zero blanking enable, sampled live.
- update  input  1  one-cycle strobe: capture bcd_in/dp_in into the shadow register.
- bcd_in  input  16  four BCD digits; [3:0] is digit 0 (rightmost).
- dp_in  input  4  decimal-point mask, bit i lights the DP of digit i.
- an  output  4  anode selects, active low, one-hot-low while driving.
- sseg  output  7  segments gfedcba, active low.
- dp  output  1  decimal point, active low.
- frame_start  output  1  one-cycle pulse on the first cycle of the digit 0 slot.

## Operation
- Slot counter counts 0..PRESCALE-1, then wraps. Digit index advances 0→1→2→3→0 on each wrap.
- Per-slot FSM:
  - BLANK: slot count < DEAD. an=4'hF, sseg=7'h7F, dp=1.
  - DRIVE: slot count ≥ DEAD. an has bit[idx]=0, all other bits 1. sseg = decoded active digit. dp = ~active_dp[idx].
- Decoding: codes 0–9 give standard glyphs. Codes 10–14 give the decoder's error glyph, which is segments a,d,g lit (7'b0110110). Code 15 forces a blank digit.
- Leading-zero blanking (lzb=1): digit i (i=3..1) is blanked when it and every more-significant digit equal 0. Digit 0 is never blanked. A blanked digit still shows its DP if its mask bit is set.
- en=0: an=4'hF, sseg=7'h7F, dp=1. FSM, counters and the update path are unaffected.
- Update path:
  - update=1 writes the shadow register and sets pending.
  - At the frame boundary (slot wrap from digit 3 to digit 0), if pending is set, the shadow is copied to the active register and pending is cleared.
  - If update coincides with the frame boundary, the incoming bcd_in/dp_in are written straight to the active register and pending ends cleared.
  - Multiple updates within one frame: the last one wins.

## Timing
- All outputs are registered and reflect the FSM state of the previous cycle (one-cycle latency from counter to pins).
- Frame period = 4·PRESCALE cycles. DRIVE duty = (PRESCALE-DEAD)/PRESCALE per digit.
- A value captured by update appears on the pins no earlier than the first DRIVE cycle of the next digit 0 slot, plus one cycle.
- frame_start is asserted in the same output cycle as the first BLANK cycle of digit 0.
- Reset values (asynchronous assertion):
  - an=4'hF, sseg=7'h7F, dp=1, frame_start=0.
  - Slot counter 0, idx 0, state BLANK.
  - Active, shadow and pending all 0.
- Release: counting starts on the first clock edge after rst_n rises. With lzb=1 the display shows "   0".
- Reset asserted mid-slot returns all outputs to reset values immediately and discards any pending update.

## Structure
- Shared package: digit count (4), blank code (4'hF), the BLANK/DRIVE state encoding, the all-off constants 4'hF and 7'h7F.
- One sub-module: the team's existing combinational BCD-to-segment decoder bcd2sseg, instantiated once on the muxed digit. The controller overrides its output for code 15, leading-zero blanking, BLANK and en=0.
- The prescaler, index counter, FSM and update registers all live in one module. No other sub-modules.

## Test plan
- Use PRESCALE=8, DEAD=2 throughout.
- Reset, then run 32 cycles with lzb=0 → an cycles 1110,1101,1011,0111, each low for 6 cycles after 2 blank cycles; sseg=7'b1000000 in every DRIVE cycle.
- update with bcd_in=16'h1234, dp_in=4'b0100, mid-frame → pins unchanged until the next frame_start. The following frame shows 4,3,2,1 on digits 0..3, with dp=0 only during digit 2.
- lzb=1, bcd_in=16'h0070 → digits 3 and 2 blank (sseg=7'h7F, anode still pulsed); digit 1 shows 7 (7'b1111000); digit 0 shows 0.
- bcd_in=16'hFA0C → digit 3 blank, digit 2 and digit 0 show 7'b0110110, digit 1 shows 0.
- update asserted on the exact frame-boundary cycle with 16'h9999, then another update with 16'h5555 two cycles later → the frame shows 9999; 5555 appears one frame later.
- Drop rst_n during a DRIVE cycle of digit 2 with an update pending → outputs go to all-off within the same cycle; after release the display shows active value 0 and the pending value is lost.
